// File: rtl/round_ctrl_pkg.sv
// Shared types and constants for the shooter match controller.
// Used by round_ctrl (FSM, optional round timer) and its testbench.
package round_ctrl_pkg;

    // Match states as seen by the renderer on o_state.
    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_PLAY  = 3'd1,
        S_PAUSE = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4
    } game_state_e;

    // Upper bound on N_ENEMY; also sizes the enemy HP sum used by the timer.
    localparam int MAX_ENEMY = 8;

    // Width of the round timer output.
    localparam int TIMER_W = 16;

    // True while hits and invincibility counters are live.
    function automatic logic state_runs(input game_state_e st);
        return (st == S_PLAY);
    endfunction

endpackage

// File: rtl/hp_tracker.sv
// One entity's hit points and post-hit invincibility counter.
// A hit only counts while run is high, the shield is down, the entity is
// not invincible and it still has HP. A counted hit removes one HP and
// arms the invincibility counter, which then runs down on frame ticks
// only while run is high (so it freezes during pause).
module hp_tracker
    import round_ctrl_pkg::*;
#(
    parameter int HP_W   = 3,
    parameter int HP_MAX = 5,
    parameter int IFRAME = 30
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            frame_tick,
    input  logic            hit,
    input  logic            shield,
    input  logic            reload,
    input  logic            run,
    output logic [HP_W-1:0] hp,
    output logic            inv
);

    localparam int IW = (IFRAME > 0) ? $clog2(IFRAME + 1) : 1;

    logic [HP_W-1:0] hp_q, hp_d;
    logic [IW-1:0]   inv_q, inv_d;
    logic            hit_ok_s;

    // Decide whether this cycle's hit counts and compute next HP / counter.
    always_comb begin
        hp_d     = hp_q;
        inv_d    = inv_q;
        hit_ok_s = hit && !shield && (inv_q == {IW{1'b0}}) && (hp_q != {HP_W{1'b0}});
        if (reload) begin
            hp_d  = HP_W'(HP_MAX);
            inv_d = {IW{1'b0}};
        end else if (run) begin
            if (hit_ok_s) begin
                hp_d  = hp_q - HP_W'(1'b1);
                inv_d = IW'(IFRAME);
            end else if (frame_tick && (inv_q != {IW{1'b0}})) begin
                inv_d = inv_q - IW'(1'b1);
            end else begin
                inv_d = inv_q;
            end
        end else begin
            hp_d  = hp_q;
            inv_d = inv_q;
        end
    end

    // HP and invincibility registers; reset loads a full health bar.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_q  <= HP_W'(HP_MAX);
            inv_q <= {IW{1'b0}};
        end else begin
            hp_q  <= hp_d;
            inv_q <= inv_d;
        end
    end

    assign hp  = hp_q;
    assign inv = (inv_q != {IW{1'b0}});

endmodule

// File: rtl/round_ctrl.sv
// Match controller for the shooter game: game-state FSM, player and enemy
// HP trackers, pause handling and the round_start pulse that re-initialises
// the movement/bullet blocks.
// Optional feature: define ROUND_TIMER_EN to enable a frame-counted round
// timer; without it o_timer is tied to zero and a round ends only on HP.
module round_ctrl
    import round_ctrl_pkg::*;
#(
    parameter int N_ENEMY      = 2,
    parameter int HP_W         = 3,
    parameter int HP_MAX       = 5,
    parameter int IFRAME       = 30,
    parameter int ROUND_FRAMES = 3600
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_tick,
    input  logic                      select,
    input  logic                      pause,
    input  logic                      player_hit,
    input  logic                      player_shield,
    input  logic [N_ENEMY-1:0]        enemy_hit,
    input  logic [N_ENEMY-1:0]        enemy_shield,
    output logic [2:0]                o_state,
    output logic                      o_round_start,
    output logic [HP_W-1:0]           o_player_hp,
    output logic [N_ENEMY*HP_W-1:0]   o_enemy_hp,
    output logic [N_ENEMY-1:0]        o_enemy_alive,
    output logic                      o_player_inv,
    output logic [TIMER_W-1:0]        o_timer
);

    // Reject configurations the counters cannot represent.
    generate
        if (N_ENEMY < 1 || N_ENEMY > MAX_ENEMY) begin : g_bad_n
            $error("round_ctrl: N_ENEMY out of range");
        end
        if (HP_MAX < 1 || HP_MAX > (2 ** HP_W) - 1) begin : g_bad_hp
            $error("round_ctrl: HP_MAX out of range");
        end
        if (ROUND_FRAMES < 0 || ROUND_FRAMES > (2 ** TIMER_W) - 1) begin : g_bad_rf
            $error("round_ctrl: ROUND_FRAMES out of range");
        end
    endgenerate

    game_state_e             state_q, state_d;
    logic                    round_start_q, round_start_d;
    logic                    reload_s;
    logic                    run_s;
    logic                    all_dead_s;
    logic                    timer_win_s;
    logic                    timer_lose_s;
    logic [HP_W-1:0]         player_hp_s;
    logic [N_ENEMY*HP_W-1:0] enemy_hp_s;
    logic [N_ENEMY-1:0]      enemy_inv_s;

    // Reload happens on the START->PLAY edge so the new round opens with full HP.
    assign reload_s = (state_q == S_START) && select;
    assign run_s    = state_runs(state_q);

    hp_tracker #(
        .HP_W   (HP_W),
        .HP_MAX (HP_MAX),
        .IFRAME (IFRAME)
    ) u_player (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .hit        (player_hit),
        .shield     (player_shield),
        .reload     (reload_s),
        .run        (run_s),
        .hp         (player_hp_s),
        .inv        (o_player_inv)
    );

    generate
        for (genvar i = 0; i < N_ENEMY; i++) begin : g_enemy
            hp_tracker #(
                .HP_W   (HP_W),
                .HP_MAX (HP_MAX),
                .IFRAME (IFRAME)
            ) u_enemy (
                .clk        (clk),
                .rst_n      (rst_n),
                .frame_tick (frame_tick),
                .hit        (enemy_hit[i]),
                .shield     (enemy_shield[i]),
                .reload     (reload_s),
                .run        (run_s),
                .hp         (enemy_hp_s[i*HP_W +: HP_W]),
                .inv        (enemy_inv_s[i])
            );
            assign o_enemy_alive[i] = (enemy_hp_s[i*HP_W +: HP_W] != {HP_W{1'b0}});
        end
    endgenerate

    assign all_dead_s = (o_enemy_alive == {N_ENEMY{1'b0}});

`ifdef ROUND_TIMER_EN
    localparam int SUM_W = HP_W + 4;

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [SUM_W-1:0]   enemy_sum_s;
    logic               player_ahead_s;

    // Total remaining enemy HP decides the winner when time runs out.
    always_comb begin
        enemy_sum_s = {SUM_W{1'b0}};
        for (int k = 0; k < N_ENEMY; k++) begin
            enemy_sum_s = enemy_sum_s + SUM_W'(enemy_hp_s[k*HP_W +: HP_W]);
        end
        player_ahead_s = (SUM_W'(player_hp_s) > enemy_sum_s);
    end

    // Timer loads at round start and counts frames only while playing.
    always_comb begin
        timer_d = timer_q;
        if (reload_s) begin
            timer_d = TIMER_W'(ROUND_FRAMES);
        end else if (run_s && frame_tick && (timer_q != {TIMER_W{1'b0}})) begin
            timer_d = timer_q - TIMER_W'(1'b1);
        end else begin
            timer_d = timer_q;
        end
    end

    // Round timer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= {TIMER_W{1'b0}};
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timer_win_s  = run_s && (timer_q == {TIMER_W{1'b0}}) && player_ahead_s;
    assign timer_lose_s = run_s && (timer_q == {TIMER_W{1'b0}}) && !player_ahead_s;
    assign o_timer      = timer_q;
`else
    assign timer_win_s  = 1'b0;
    assign timer_lose_s = 1'b0;
    assign o_timer      = {TIMER_W{1'b0}};
`endif

    // Next-state logic; HP outcomes beat timer expiry, which beats pause.
    always_comb begin
        state_d       = state_q;
        round_start_d = 1'b0;
        case (state_q)
            S_START: begin
                if (select) begin
                    state_d       = S_PLAY;
                    round_start_d = 1'b1;
                end else begin
                    state_d = S_START;
                end
            end
            S_PLAY: begin
                if (player_hp_s == {HP_W{1'b0}}) begin
                    state_d = S_LOSE;
                end else if (all_dead_s) begin
                    state_d = S_WIN;
                end else if (timer_win_s) begin
                    state_d = S_WIN;
                end else if (timer_lose_s) begin
                    state_d = S_LOSE;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_PAUSE: begin
                if (pause) begin
                    state_d = S_PLAY;
                end else begin
                    state_d = S_PAUSE;
                end
            end
            S_WIN, S_LOSE: begin
                if (select) begin
                    state_d = S_START;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_START;
            end
        endcase
    end

    // State and round_start registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_START;
            round_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            round_start_q <= round_start_d;
        end
    end

    assign o_state       = state_q;
    assign o_round_start = round_start_q;
    assign o_player_hp   = player_hp_s;
    assign o_enemy_hp    = enemy_hp_s;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed self-checking bench for round_ctrl (default parameters).
// A second instance with ROUND_FRAMES=10 exercises the round timer, whose
// expected behaviour depends on whether ROUND_TIMER_EN is defined.
module tb_round_ctrl;
    import round_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick, select, pause, player_hit, player_shield;
    logic [1:0] enemy_hit, enemy_shield;
    logic [2:0] o_state;
    logic       o_round_start, o_player_inv;
    logic [2:0] o_player_hp;
    logic [5:0] o_enemy_hp;
    logic [1:0] o_enemy_alive;
    logic [15:0] o_timer;

    logic       t_frame_tick, t_select, t_zero;
    logic [1:0] t_zero2;
    logic [2:0] t_state;
    logic       t_round_start, t_player_inv;
    logic [2:0] t_player_hp;
    logic [5:0] t_enemy_hp;
    logic [1:0] t_enemy_alive;
    logic [15:0] t_timer;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    round_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .select(select),
        .pause(pause), .player_hit(player_hit), .player_shield(player_shield),
        .enemy_hit(enemy_hit), .enemy_shield(enemy_shield), .o_state(o_state),
        .o_round_start(o_round_start), .o_player_hp(o_player_hp),
        .o_enemy_hp(o_enemy_hp), .o_enemy_alive(o_enemy_alive),
        .o_player_inv(o_player_inv), .o_timer(o_timer)
    );

    round_ctrl #(.ROUND_FRAMES(10)) u_tmr (
        .clk(clk), .rst_n(rst_n), .frame_tick(t_frame_tick), .select(t_select),
        .pause(t_zero), .player_hit(t_zero), .player_shield(t_zero),
        .enemy_hit(t_zero2), .enemy_shield(t_zero2), .o_state(t_state),
        .o_round_start(t_round_start), .o_player_hp(t_player_hp),
        .o_enemy_hp(t_enemy_hp), .o_enemy_alive(t_enemy_alive),
        .o_player_inv(t_player_inv), .o_timer(t_timer)
    );

    // One clock; outputs are then stable 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        frame_tick = 1'b1;
        repeat (n) step();
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++; if (o_state !== 3'(S_START)) begin errors++; $display("FAIL reset_state got %0d exp %0d", o_state, S_START); end
        checks++; if (o_player_hp !== 3'd5) begin errors++; $display("FAIL reset_player_hp got %0d exp 5", o_player_hp); end
        checks++; if (o_enemy_hp !== 6'b101101) begin errors++; $display("FAIL reset_enemy_hp got %b exp 101101", o_enemy_hp); end
        checks++; if (o_round_start !== 1'b0) begin errors++; $display("FAIL reset_round_start got %b exp 0", o_round_start); end
        checks++; if (o_timer !== 16'd0) begin errors++; $display("FAIL reset_timer got %0d exp 0", o_timer); end
        checks++; if (o_player_inv !== 1'b0) begin errors++; $display("FAIL reset_inv got %b exp 0", o_player_inv); end
        @(negedge clk);
        rst_n = 1'b1;
        pause = 1'b1;
        step();
        pause = 1'b0;
        checks++; if (o_state !== 3'(S_START)) begin errors++; $display("FAIL pause_in_start got %0d exp %0d", o_state, S_START); end
    endtask

    task automatic test_start();
        select = 1'b1;
        step();
        select = 1'b0;
        checks++; if (o_state !== 3'(S_PLAY)) begin errors++; $display("FAIL start_state got %0d exp %0d", o_state, S_PLAY); end
        checks++; if (o_round_start !== 1'b1) begin errors++; $display("FAIL round_start_hi got %b exp 1", o_round_start); end
        step();
        checks++; if (o_round_start !== 1'b0) begin errors++; $display("FAIL round_start_1cyc got %b exp 0", o_round_start); end
        checks++; if (o_enemy_hp !== {3'd5, 3'd5}) begin errors++; $display("FAIL start_enemy_hp got %b exp 101101", o_enemy_hp); end
        checks++; if (o_player_hp !== 3'd5) begin errors++; $display("FAIL start_player_hp got %0d exp 5", o_player_hp); end
        checks++; if (o_enemy_alive !== 2'b11) begin errors++; $display("FAIL start_alive got %b exp 11", o_enemy_alive); end
    endtask

    task automatic test_player_hit();
        player_hit = 1'b1; step(); player_hit = 1'b0;
        checks++; if (o_player_hp !== 3'd4) begin errors++; $display("FAIL hit1_hp got %0d exp 4", o_player_hp); end
        checks++; if (o_player_inv !== 1'b1) begin errors++; $display("FAIL hit1_inv got %b exp 1", o_player_inv); end
        frames(10);
        player_hit = 1'b1; step(); player_hit = 1'b0;
        checks++; if (o_player_hp !== 3'd4) begin errors++; $display("FAIL hit_during_inv got %0d exp 4", o_player_hp); end
        frames(20);
        checks++; if (o_player_inv !== 1'b0) begin errors++; $display("FAIL inv_expired got %b exp 0", o_player_inv); end
        player_hit = 1'b1; step(); player_hit = 1'b0;
        checks++; if (o_player_hp !== 3'd3) begin errors++; $display("FAIL hit_after_inv got %0d exp 3", o_player_hp); end
        player_shield = 1'b1;
        frames(31);
        player_hit = 1'b1; step(); player_hit = 1'b0;
        player_shield = 1'b0;
        checks++; if (o_player_hp !== 3'd3) begin errors++; $display("FAIL player_shield got %0d exp 3", o_player_hp); end
    endtask

    task automatic test_enemy_kill();
        enemy_shield = 2'b01; enemy_hit = 2'b01; step(); enemy_hit = 2'b00; enemy_shield = 2'b00;
        checks++; if (o_enemy_hp !== {3'd5, 3'd5}) begin errors++; $display("FAIL enemy_shield got %b exp 101101", o_enemy_hp); end
        select = 1'b1; step(); select = 1'b0;
        checks++; if (o_state !== 3'(S_PLAY)) begin errors++; $display("FAIL select_in_play got %0d exp %0d", o_state, S_PLAY); end
        for (int i = 0; i < 5; i++) begin
            enemy_hit = 2'b01; step(); enemy_hit = 2'b00;
            frames(31);
        end
        checks++; if (o_enemy_hp !== {3'd5, 3'd0}) begin errors++; $display("FAIL enemy0_dead_hp got %b exp 101000", o_enemy_hp); end
        checks++; if (o_enemy_alive !== 2'b10) begin errors++; $display("FAIL enemy0_alive got %b exp 10", o_enemy_alive); end
        checks++; if (o_state !== 3'(S_PLAY)) begin errors++; $display("FAIL one_dead_state got %0d exp %0d", o_state, S_PLAY); end
        enemy_hit = 2'b01; step(); enemy_hit = 2'b00;
        checks++; if (o_enemy_hp !== {3'd5, 3'd0}) begin errors++; $display("FAIL dead_hit got %b exp 101000", o_enemy_hp); end
        for (int i = 0; i < 4; i++) begin
            enemy_hit = 2'b10; step(); enemy_hit = 2'b00;
            frames(31);
        end
        checks++; if (o_enemy_hp !== {3'd1, 3'd0}) begin errors++; $display("FAIL enemy1_hp1 got %b exp 001000", o_enemy_hp); end
        enemy_hit = 2'b10; step(); enemy_hit = 2'b00;
        checks++; if (o_state !== 3'(S_PLAY)) begin errors++; $display("FAIL win_latency got %0d exp %0d", o_state, S_PLAY); end
        step();
        checks++; if (o_state !== 3'(S_WIN)) begin errors++; $display("FAIL win_state got %0d exp %0d", o_state, S_WIN); end
        pause = 1'b1; step(); pause = 1'b0;
        checks++; if (o_state !== 3'(S_WIN)) begin errors++; $display("FAIL pause_in_win got %0d exp %0d", o_state, S_WIN); end
        select = 1'b1; step(); select = 1'b0;
        checks++; if (o_state !== 3'(S_START)) begin errors++; $display("FAIL win_to_start got %0d exp %0d", o_state, S_START); end
        checks++; if (o_round_start !== 1'b0) begin errors++; $display("FAIL no_pulse_to_start got %b exp 0", o_round_start); end
    endtask

    task automatic test_simultaneous_lose();
        select = 1'b1; step(); select = 1'b0;
        checks++; if (o_player_hp !== 3'd5) begin errors++; $display("FAIL reload_player got %0d exp 5", o_player_hp); end
        checks++; if (o_enemy_hp !== {3'd5, 3'd5}) begin errors++; $display("FAIL reload_enemy got %b exp 101101", o_enemy_hp); end
        for (int i = 0; i < 4; i++) begin
            player_hit = 1'b1; enemy_hit = 2'b11; step(); player_hit = 1'b0; enemy_hit = 2'b00;
            frames(31);
        end
        checks++; if (o_player_hp !== 3'd1) begin errors++; $display("FAIL multi_player got %0d exp 1", o_player_hp); end
        checks++; if (o_enemy_hp !== {3'd1, 3'd1}) begin errors++; $display("FAIL multi_enemy got %b exp 001001", o_enemy_hp); end
        enemy_hit = 2'b01; step(); enemy_hit = 2'b00;
        frames(31);
        player_hit = 1'b1; enemy_hit = 2'b10; step(); player_hit = 1'b0; enemy_hit = 2'b00;
        checks++; if ({o_player_hp, o_enemy_hp} !== 9'd0) begin errors++; $display("FAIL both_zero got %b exp 0", {o_player_hp, o_enemy_hp}); end
        step();
        checks++; if (o_state !== 3'(S_LOSE)) begin errors++; $display("FAIL tie_lose got %0d exp %0d", o_state, S_LOSE); end
    endtask

    task automatic test_pause();
        select = 1'b1; step(); step(); select = 1'b0;
        checks++; if (o_state !== 3'(S_PLAY)) begin errors++; $display("FAIL restart got %0d exp %0d", o_state, S_PLAY); end
        player_hit = 1'b1; step(); player_hit = 1'b0;
        frames(5);
        pause = 1'b1; step(); pause = 1'b0;
        checks++; if (o_state !== 3'(S_PAUSE)) begin errors++; $display("FAIL paused got %0d exp %0d", o_state, S_PAUSE); end
        frames(100);
        enemy_hit = 2'b11; step(); enemy_hit = 2'b00;
        checks++; if (o_enemy_hp !== {3'd5, 3'd5}) begin errors++; $display("FAIL hit_in_pause got %b exp 101101", o_enemy_hp); end
        select = 1'b1; step(); select = 1'b0;
        checks++; if (o_state !== 3'(S_PAUSE)) begin errors++; $display("FAIL select_in_pause got %0d exp %0d", o_state, S_PAUSE); end
        pause = 1'b1; step(); pause = 1'b0;
        checks++; if (o_state !== 3'(S_PLAY) || o_round_start !== 1'b0) begin errors++; $display("FAIL unpause got %0d/%b exp %0d/0", o_state, o_round_start, S_PLAY); end
        frames(24);
        checks++; if (o_player_inv !== 1'b1) begin errors++; $display("FAIL inv_held got %b exp 1", o_player_inv); end
        frames(1);
        checks++; if (o_player_inv !== 1'b0) begin errors++; $display("FAIL inv_resume got %b exp 0", o_player_inv); end
        player_hit = 1'b1; pause = 1'b1; step(); player_hit = 1'b0; pause = 1'b0;
        checks++; if (o_player_hp !== 3'd3 || o_state !== 3'(S_PAUSE)) begin errors++; $display("FAIL hit_with_pause got %0d/%0d exp 3/%0d", o_player_hp, o_state, S_PAUSE); end
        pause = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        checks++; if (o_state !== 3'(S_START) || o_player_hp !== 3'd5) begin errors++; $display("FAIL async_reset got %0d/%0d exp %0d/5", o_state, o_player_hp, S_START); end
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        pause = 1'b0;
        checks++; if (o_state !== 3'(S_START) || o_enemy_hp !== 6'b101101 || o_player_inv !== 1'b0) begin errors++; $display("FAIL after_reset got %0d/%b/%b exp %0d/101101/0", o_state, o_enemy_hp, o_player_inv, S_START); end
    endtask

    task automatic test_timer();
        t_select = 1'b1; step(); t_select = 1'b0;
        checks++; if (t_state !== 3'(S_PLAY)) begin errors++; $display("FAIL tmr_start got %0d exp %0d", t_state, S_PLAY); end
`ifdef ROUND_TIMER_EN
        checks++; if (t_timer !== 16'd10) begin errors++; $display("FAIL tmr_load got %0d exp 10", t_timer); end
`endif
        t_frame_tick = 1'b1;
        repeat (10) step();
        t_frame_tick = 1'b0;
        checks++; if (t_timer !== 16'd0 || t_state !== 3'(S_PLAY)) begin errors++; $display("FAIL tmr_zero got %0d/%0d exp 0/%0d", t_timer, t_state, S_PLAY); end
        step();
`ifdef ROUND_TIMER_EN
        checks++; if (t_state !== 3'(S_LOSE)) begin errors++; $display("FAIL tmr_expire got %0d exp %0d", t_state, S_LOSE); end
`else
        checks++; if (t_state !== 3'(S_PLAY) || t_timer !== 16'd0) begin errors++; $display("FAIL tmr_off got %0d/%0d exp %0d/0", t_state, t_timer, S_PLAY); end
`endif
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; select = 1'b0; pause = 1'b0;
        player_hit = 1'b0; player_shield = 1'b0; enemy_hit = 2'b00; enemy_shield = 2'b00;
        t_frame_tick = 1'b0; t_select = 1'b0; t_zero = 1'b0; t_zero2 = 2'b00;
        test_reset();
        test_start();
        test_player_hit();
        test_enemy_kill();
        test_simultaneous_lose();
        test_pause();
        test_timer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
